// File: rtl/capture_sample_scheduler.sv
// capture_sample_scheduler
// Picks a 16x16 grid of pixels out of the 224x224 capture field once per
// update period, averages them and offers the result to the HEX readout
// path over a valid/ready handshake. Pixels arrive one per clock together
// with their raster coordinates, so a sample point is recognised purely by
// comparing the current (X,Y) against the grid positions.
//
// Sequence per update period:
//   IDLE -> ARM      at the frame start that closes an update period (unless frozen)
//   ARM  -> ACCUM    when the top-left grid point arrives (it is accumulated)
//   ACCUM-> DONE     when the last grid point has been accumulated
//   ACCUM-> IDLE     if a new frame starts before the grid is complete (drop)
//   DONE -> PRESENT  averages are latched into the output registers
//   PRESENT -> IDLE  when the consumer takes the sample
module capture_sample_scheduler #(
    parameter int FIELD_X0      = 208,
    parameter int FIELD_Y0      = 128,
    parameter int STEP          = 14,
    parameter int GRID          = 16,
    parameter int UPDATE_FRAMES = 60
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [10:0] X,
    input  logic [10:0] Y,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    input  logic        FREEZE,
    input  logic        iREADY,
    output logic        oVALID,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic [5:0]  oFRAME_CNT,
    output logic        oDROP,
    output logic        oSKIP
);

    // The grid always holds 256 points, so the average is the top byte of a
    // 16-bit sum; 255 * 256 = 65280 still fits, so no saturation is needed.
    localparam int NPTS  = GRID * GRID;
    localparam int CNT_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_DONE    = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    state_t             state_r;
    state_t             next_state_s;

    logic [5:0]         frame_cnt_r;
    logic [15:0]        sum_red_r;
    logic [15:0]        sum_grn_r;
    logic [15:0]        sum_blu_r;
    logic [CNT_W-1:0]   pt_cnt_r;

    logic               valid_r;
    logic [7:0]         red_r;
    logic [7:0]         grn_r;
    logic [7:0]         blu_r;
    logic               drop_r;
    logic               skip_r;

    logic               frame_start_s;
    logic               update_due_s;
    logic               col_hit_s;
    logic               row_hit_s;
    logic               sample_pt_s;
    logic               first_pt_s;
    logic               last_pt_s;

    logic               valid_nx_s;
    logic               load_out_s;
    logic               drop_nx_s;
    logic               skip_nx_s;

    // Raster position decode: frame start, update boundary and grid hits.
    always_comb begin
        frame_start_s = (X == 11'd0) && (Y == 11'd0);
        update_due_s  = frame_start_s && (frame_cnt_r == 6'(UPDATE_FRAMES - 1));
        col_hit_s     = 1'b0;
        row_hit_s     = 1'b0;
        for (int i = 0; i < GRID; i++) begin
            col_hit_s = col_hit_s | (X == 11'(FIELD_X0 + i * STEP));
            row_hit_s = row_hit_s | (Y == 11'(FIELD_Y0 + i * STEP));
        end
        sample_pt_s = col_hit_s && row_hit_s;
        first_pt_s  = (X == 11'(FIELD_X0)) && (Y == 11'(FIELD_Y0));
        // pt_cnt_r counts points already summed, so NPTS-1 means this is the last one.
        last_pt_s   = sample_pt_s && (pt_cnt_r == CNT_W'(NPTS - 1));
    end

    // Frame counter: advances on every frame start, wraps at the update period.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_cnt_r <= 6'd0;
        end else if (frame_start_s) begin
            if (frame_cnt_r == 6'(UPDATE_FRAMES - 1)) begin
                frame_cnt_r <= 6'd0;
            end else begin
                frame_cnt_r <= frame_cnt_r + 6'd1;
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a frame start in ACCUM wins over the last point.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                // FREEZE only matters at the update boundary.
                if (update_due_s && !FREEZE) begin
                    next_state_s = ST_ARM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (first_pt_s) begin
                    next_state_s = ST_ACCUM;
                end else begin
                    next_state_s = ST_ARM;
                end
            end
            ST_ACCUM: begin
                if (frame_start_s) begin
                    next_state_s = ST_IDLE;
                end else if (last_pt_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                next_state_s = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (valid_r && iREADY) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_PRESENT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode; all of these are registered before leaving the block.
    always_comb begin
        valid_nx_s = (next_state_s == ST_PRESENT);
        load_out_s = (state_r == ST_DONE);
        drop_nx_s  = (state_r == ST_ACCUM) && frame_start_s;
        // A sample accepted on the boundary cycle is not counted as skipped.
        skip_nx_s  = (state_r == ST_PRESENT) && update_due_s && !(valid_r && iREADY);
    end

    // Colour accumulators and point counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sum_red_r <= 16'd0;
            sum_grn_r <= 16'd0;
            sum_blu_r <= 16'd0;
            pt_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_ARM: begin
                    // Sums start fresh; the first grid point seeds them directly.
                    if (first_pt_s) begin
                        sum_red_r <= {8'd0, iR};
                        sum_grn_r <= {8'd0, iG};
                        sum_blu_r <= {8'd0, iB};
                        pt_cnt_r  <= CNT_W'(1);
                    end else begin
                        sum_red_r <= 16'd0;
                        sum_grn_r <= 16'd0;
                        sum_blu_r <= 16'd0;
                        pt_cnt_r  <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (frame_start_s) begin
                        sum_red_r <= 16'd0;
                        sum_grn_r <= 16'd0;
                        sum_blu_r <= 16'd0;
                        pt_cnt_r  <= '0;
                    end else if (sample_pt_s) begin
                        sum_red_r <= sum_red_r + {8'd0, iR};
                        sum_grn_r <= sum_grn_r + {8'd0, iG};
                        sum_blu_r <= sum_blu_r + {8'd0, iB};
                        pt_cnt_r  <= pt_cnt_r + CNT_W'(1);
                    end else begin
                        pt_cnt_r  <= pt_cnt_r;
                    end
                end
                default: begin
                    pt_cnt_r <= pt_cnt_r;
                end
            endcase
        end
    end

    // Output registers: averaged colour is held until the next DONE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= 1'b0;
            red_r   <= 8'd0;
            grn_r   <= 8'd0;
            blu_r   <= 8'd0;
            drop_r  <= 1'b0;
            skip_r  <= 1'b0;
        end else begin
            valid_r <= valid_nx_s;
            drop_r  <= drop_nx_s;
            skip_r  <= skip_nx_s;
            if (load_out_s) begin
                // Divide by 256 by taking the top byte (truncating).
                red_r <= sum_red_r[15:8];
                grn_r <= sum_grn_r[15:8];
                blu_r <= sum_blu_r[15:8];
            end else begin
                red_r <= red_r;
                grn_r <= grn_r;
                blu_r <= blu_r;
            end
        end
    end

    assign oVALID     = valid_r;
    assign oR         = red_r;
    assign oG         = grn_r;
    assign oB         = blu_r;
    assign oFRAME_CNT = frame_cnt_r;
    assign oDROP      = drop_r;
    assign oSKIP      = skip_r;

endmodule
